text_write_controller: RTL
==========================

TEXT_WRITE_CONTROLLER -- requirements
Module: text_write_controller

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 Parameter BLANK_CHAR, default 7'h20, code written to erased cells.
REQ-004 Parameter BLINK_DIV, default 25_000_000, clk cycles per cursor blink half-period (CURSOR_BLINK_EN only).
REQ-005 clk  input  1  single system clock; all logic on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_char holds a character to process.
REQ-008 in_char  input  7  character code from the keyboard/UART source.
REQ-009 in_ready  output  1  controller accepts in_char this cycle.
REQ-010 clear_req  input  1  one-cycle request to blank the whole screen.
REQ-011 wr_en  output  1  text buffer write strobe.
REQ-012 wr_x  output  7  text buffer write column.
REQ-013 wr_y  output  5  text buffer write row.
REQ-014 wr_char  output  7  text buffer write data.
REQ-015 cursor_x  output  7  current cursor column.
REQ-016 cursor_y  output  5  current cursor row.
REQ-017 busy  output  1  high while in CLEAR state.
REQ-018 cursor_on  output  1  cursor highlight; present only with CURSOR_BLINK_EN.

Function
REQ-019 FSM has two states, IDLE and CLEAR; leaving reset the FSM is in CLEAR.
REQ-020 in_ready is combinational: high iff state is IDLE and clear_req is low.
REQ-021 A character is accepted on a cycle where in_valid and in_ready are both high; in_char is not sampled otherwise.
REQ-022 Every write is registered: wr_en, wr_x, wr_y, wr_char are valid the cycle after acceptance, and wr_en is high for exactly one cycle per write.
REQ-023 Printable code (7'h20 to 7'h7E) writes in_char at (cursor_x, cursor_y), then advances cursor_x by one.
REQ-024 Advance past column COLS-1 sets cursor_x to 0 and advances cursor_y; advance past row ROWS-1 sets cursor_y to 0 (wrap, no scroll).
REQ-025 7'h0D or 7'h0A (newline) sets cursor_x to 0 and advances cursor_y with the wrap rule of REQ-024, with no write.
REQ-026 7'h08 or 7'h7F (backspace): if cursor_x>0, decrement cursor_x; else if cursor_y>0, set cursor_x to COLS-1 and decrement cursor_y; else cursor stays at (0,0); then BLANK_CHAR is written at the new cursor position.
REQ-027 Any other code below 7'h20 is accepted and discarded: no write, no cursor change.
REQ-028 cursor_x/cursor_y update in the same cycle that the corresponding write is presented.
REQ-029 clear_req high in IDLE moves the FSM to CLEAR on the next edge; clear_req on the same cycle as in_valid wins, and the character is not accepted.
REQ-030 CLEAR writes BLANK_CHAR to every cell in row-major order, one cell per cycle, starting at (0,0), for COLS*ROWS consecutive wr_en cycles.
REQ-031 After the write to (COLS-1, ROWS-1), CLEAR sets the cursor to (0,0) and returns to IDLE on the next cycle.
REQ-032 clear_req asserted during CLEAR is ignored; the clear does not restart.
REQ-033 cursor_x and cursor_y hold their pre-clear values during CLEAR.
REQ-034 cursor_x is always below COLS and cursor_y is always below ROWS; all column/row arithmetic wraps explicitly, never through width overflow.

Reset
REQ-035 While reset is low: state is CLEAR with sweep counter at (0,0), wr_en 0, wr_x 0, wr_y 0, wr_char BLANK_CHAR, cursor_x 0, cursor_y 0, busy 1, in_ready 0, cursor_on 0.
REQ-036 Reset asserted mid-clear or mid-write aborts the operation immediately; after release a full clear runs from (0,0).

Configuration
REQ-037 Macro CURSOR_BLINK_EN defined: a counter toggles cursor_on every BLINK_DIV cycles in IDLE; any accepted character forces cursor_on to 1 and restarts the counter; cursor_on is 0 in CLEAR.
REQ-038 Macro CURSOR_BLINK_EN undefined: the cursor_on port and blink counter are absent; all other behaviour is identical.

Verification
REQ-039 Release reset -> busy high for 2400 cycles, 2400 wr_en pulses of 7'h20 covering (0,0) to (79,29), then in_ready=1 and cursor (0,0).
REQ-040 Send 'A' (7'h41) at (0,0) -> next cycle wr_en=1, wr_x=0, wr_y=0, wr_char=7'h41; cursor becomes (1,0).
REQ-041 Send printable at cursor (79,29) -> write at (79,29), cursor wraps to (0,0).
REQ-042 Backspace at (0,5) -> write 7'h20 at (79,4), cursor (79,4); backspace at (0,0) -> write 7'h20 at (0,0), cursor (0,0).
REQ-043 clear_req and in_valid with 7'h42 on the same cycle -> 7'h42 not accepted, in_ready low for 2401 cycles, cursor (0,0) afterwards.
REQ-044 Reset pulse at clear cell 1000 -> wr_en low during reset, then a new 2400-cell clear from (0,0).

Source files
------------

// File: rtl/text_write_controller.sv
// Text-mode write controller: turns a character stream into text-buffer writes
// with cursor tracking and a full-screen clear sweep. Optional CURSOR_BLINK_EN adds cursor_on.
module text_write_controller #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter logic [6:0]  BLANK_CHAR = 7'h20,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [6:0] in_char,
    output logic       in_ready,
    input  logic       clear_req,
    output logic       wr_en,
    output logic [6:0] wr_x,
    output logic [4:0] wr_y,
    output logic [6:0] wr_char,
    output logic [6:0] cursor_x,
    output logic [4:0] cursor_y,
`ifdef CURSOR_BLINK_EN
    output logic       cursor_on,
`endif
    output logic       busy
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    if (BLINK_DIV == 0) begin : g_bad_blink_div
        $error("BLINK_DIV must be nonzero");
    end

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state;
    logic [6:0] sweep_x;
    logic [4:0] sweep_y;
    logic [6:0] adv_x, bs_x;
    logic [4:0] adv_y, nl_y, bs_y;

    assign in_ready = (state == IDLE) && !clear_req;
    assign busy     = (state == CLEAR);

    // Candidate cursor positions for advance, newline and backspace, all wrapping explicitly.
    always_comb begin
        nl_y = (cursor_y == LAST_ROW) ? '0 : cursor_y + 5'd1;
        if (cursor_x == LAST_COL) begin
            adv_x = '0;
            adv_y = nl_y;
        end else begin
            adv_x = cursor_x + 7'd1;
            adv_y = cursor_y;
        end
        if (cursor_x != '0) begin
            bs_x = cursor_x - 7'd1;
            bs_y = cursor_y;
        end else if (cursor_y != '0) begin
            bs_x = LAST_COL;
            bs_y = cursor_y - 5'd1;
        end else begin
            bs_x = '0;
            bs_y = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= CLEAR;
            sweep_x  <= '0;
            sweep_y  <= '0;
            wr_en    <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_char  <= BLANK_CHAR;
            cursor_x <= '0;
            cursor_y <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state   <= CLEAR;
                        sweep_x <= '0;
                        sweep_y <= '0;
                    end else if (in_valid) begin
                        if (in_char inside {[7'h20:7'h7E]}) begin
                            wr_en    <= 1'b1;
                            wr_x     <= cursor_x;
                            wr_y     <= cursor_y;
                            wr_char  <= in_char;
                            cursor_x <= adv_x;
                            cursor_y <= adv_y;
                        end else if (in_char == 7'h0D || in_char == 7'h0A) begin
                            cursor_x <= '0;
                            cursor_y <= nl_y;
                        end else if (in_char == 7'h08 || in_char == 7'h7F) begin
                            wr_en    <= 1'b1;
                            wr_x     <= bs_x;
                            wr_y     <= bs_y;
                            wr_char  <= BLANK_CHAR;
                            cursor_x <= bs_x;
                            cursor_y <= bs_y;
                        end
                    end
                end
                CLEAR: begin
                    wr_en   <= 1'b1;
                    wr_x    <= sweep_x;
                    wr_y    <= sweep_y;
                    wr_char <= BLANK_CHAR;
                    if (sweep_x == LAST_COL) begin
                        sweep_x <= '0;
                        if (sweep_y == LAST_ROW) begin
                            sweep_y  <= '0;
                            cursor_x <= '0;
                            cursor_y <= '0;
                            state    <= IDLE;
                        end else begin
                            sweep_y <= sweep_y + 5'd1;
                        end
                    end else begin
                        sweep_x <= sweep_x + 7'd1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

`ifdef CURSOR_BLINK_EN
    logic [31:0] blink_cnt;

    // Held dark while clearing or about to clear; any accepted character shows it solid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            cursor_on <= 1'b0;
        end else if (state == CLEAR || clear_req) begin
            blink_cnt <= '0;
            cursor_on <= 1'b0;
        end else if (in_valid) begin
            blink_cnt <= '0;
            cursor_on <= 1'b1;
        end else if (blink_cnt == 32'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            cursor_on <= !cursor_on;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end
`endif

endmodule
